// File: rtl/muldiv_seq.sv
// muldiv_seq: EX-stage sequencer for MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring divide).
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply, divide stays iterative.
module muldiv_seq #(
  parameter  int WIDTH = 32,
  localparam int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ismultE,
  input  logic             signedmultE,
  input  logic             isdivE,
  input  logic             signeddivE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             stallE,
  input  logic             flushE,
  output logic             stall_mdE,
  output logic             result_validE,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);

  function automatic logic [WIDTH-1:0] negW(input logic [WIDTH-1:0] v, input logic neg);
    negW = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2W(input logic [2*WIDTH-1:0] v, input logic neg);
    neg2W = neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]         stateR;
  logic [CNTW-1:0]    cntR;
  logic [WIDTH-1:0]   opR;
  logic [2*WIDTH-1:0] accR;
  logic               isDivR;
  logic               negResR;
  logic               negRemR;
  logic               divZeroR;

  logic               startS;
  logic               signedOpS;
  logic               signAS;
  logic               signBS;
  logic [WIDTH-1:0]   absAS;
  logic [WIDTH-1:0]   absBS;
  logic [WIDTH:0]     mulAddS;
  logic [WIDTH:0]     mulSumS;
  logic [WIDTH:0]     divShiftS;
  logic [WIDTH:0]     divDiffS;
  logic [2*WIDTH-1:0] iterS;
  logic [2*WIDTH-1:0] prodS;
  logic [WIDTH-1:0]   finHiS;
  logic [WIDTH-1:0]   finLoS;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fastProdS;
`endif

  // Request decode and absolute-value operands; divide wins if both requests are set.
  always_comb begin
    startS    = (ismultE | isdivE) & ~flushE & (stateR == IDLE);
    signedOpS = isdivE ? signeddivE : signedmultE;
    signAS    = signedOpS & srcaE[WIDTH-1];
    signBS    = signedOpS & srcbE[WIDTH-1];
    absAS     = negW(srcaE, signAS);
    absBS     = negW(srcbE, signBS);
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mulAddS   = accR[0] ? {1'b0, opR} : {(WIDTH+1){1'b0}};
    mulSumS   = {1'b0, accR[2*WIDTH-1:WIDTH]} + mulAddS;
    divShiftS = accR[2*WIDTH-1:WIDTH-1];
    divDiffS  = divShiftS - {1'b0, opR};
    if (isDivR) begin
      // Borrow out of the trial subtraction means the quotient bit is 0 (restore).
      if (divDiffS[WIDTH]) begin
        iterS = {divShiftS[WIDTH-1:0], accR[WIDTH-2:0], 1'b0};
      end else begin
        iterS = {divDiffS[WIDTH-1:0], accR[WIDTH-2:0], 1'b1};
      end
    end else begin
      iterS = {mulSumS, accR[WIDTH-1:1]};
    end
  end

  // Sign correction of the last iteration; remainder follows the dividend's sign.
  always_comb begin
    prodS = neg2W(iterS, negResR);
    if (isDivR) begin
      finLoS = divZeroR ? {WIDTH{1'b1}} : negW(iterS[WIDTH-1:0], negResR);
      finHiS = negW(iterS[2*WIDTH-1:WIDTH], negRemR);
    end else begin
      finLoS = prodS[WIDTH-1:0];
      finHiS = prodS[2*WIDTH-1:WIDTH];
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product of the operands presented in the start cycle.
  always_comb begin
    fastProdS = neg2W({{WIDTH{1'b0}}, absAS} * {{WIDTH{1'b0}}, absBS}, signAS ^ signBS);
  end
`endif

  // Sequencer state, working registers and registered hi/lo results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateR   <= IDLE;
      cntR     <= {CNTW{1'b0}};
      opR      <= {WIDTH{1'b0}};
      accR     <= {(2*WIDTH){1'b0}};
      isDivR   <= 1'b0;
      negResR  <= 1'b0;
      negRemR  <= 1'b0;
      divZeroR <= 1'b0;
      hi_o     <= {WIDTH{1'b0}};
      lo_o     <= {WIDTH{1'b0}};
    end else begin
      case (stateR)
        IDLE: begin
          if (startS) begin
            isDivR   <= isdivE;
            negResR  <= signAS ^ signBS;
            negRemR  <= signAS;
            divZeroR <= isdivE & (srcbE == {WIDTH{1'b0}});
            cntR     <= CNT_FULL;
            if (isdivE) begin
              opR  <= absBS;
              accR <= {{WIDTH{1'b0}}, absAS};
            end else begin
              opR  <= absAS;
              accR <= {{WIDTH{1'b0}}, absBS};
            end
`ifdef MULDIV_FAST_MUL_EN
            if (isdivE) begin
              stateR <= BUSY;
            end else begin
              hi_o   <= fastProdS[2*WIDTH-1:WIDTH];
              lo_o   <= fastProdS[WIDTH-1:0];
              stateR <= DONE;
            end
`else
            stateR <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (flushE) begin
            cntR   <= {CNTW{1'b0}};
            stateR <= IDLE;
          end else begin
            accR <= iterS;
            cntR <= cntR - CNT_ONE;
            if (cntR == CNT_ONE) begin
              hi_o   <= finHiS;
              lo_o   <= finLoS;
              stateR <= DONE;
            end
          end
        end
        DONE: begin
          if (flushE | ~stallE) begin
            stateR <= IDLE;
          end
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

  // Stall covers the start cycle and every iteration; DONE releases the pipeline.
  always_comb begin
    stall_mdE     = startS | (stateR == BUSY);
    result_validE = (stateR == DONE);
  end

endmodule
